// File: rtl/pipe_en_ctrl.sv
// Valid/ready sequencer for an enable-only N-stage shift pipeline: valid shadow, shared enable, drain, flush.
// Optional saturating stall counter output o_stall_cnt when PIPE_EN_CTRL_STALL_CNT_EN is defined.
module pipe_en_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N+1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_pipe_en,
    input  logic             i_drain,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count,
    output logic             o_busy,
    output logic             o_drain_done
`ifdef PIPE_EN_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]      o_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           r_state;
    logic [N-1:0]     r_vld_pipe;
    logic [N-1:0]     w_vld_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_drain_done;
    logic             w_tail_free;
    logic             w_accept;
    logic             w_transfer;

    // Reset gating keeps the enable low under reset even if upstream holds i_valid.
    assign w_tail_free = !r_vld_pipe[N-1] | i_ready;
    assign o_ready     = w_tail_free & (r_state != DRAIN) & !i_flush;
    assign w_accept    = i_valid & o_ready & i_rst_n;
    assign o_pipe_en   = w_tail_free & (w_accept | (r_count != '0)) & !i_flush & i_rst_n;
    assign w_transfer  = r_vld_pipe[N-1] & i_ready;
    assign w_count_nxt = r_count + CNT_W'(w_accept) - CNT_W'(w_transfer);

    assign o_valid      = r_vld_pipe[N-1];
    assign o_count      = r_count;
    assign o_busy       = (r_count != '0) | (r_state != IDLE);
    assign o_drain_done = r_drain_done;

    always_comb begin
        w_vld_nxt = r_vld_pipe;
        if (o_pipe_en) begin
            w_vld_nxt[0] = w_accept;
            for (int i = 1; i < N; i++) w_vld_nxt[i] = r_vld_pipe[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_vld_pipe   <= '0;
            r_count      <= '0;
            r_drain_done <= 1'b0;
        end else if (i_flush) begin
            r_state      <= IDLE;
            r_vld_pipe   <= '0;
            r_count      <= '0;
            r_drain_done <= 1'b0;
        end else begin
            r_vld_pipe   <= w_vld_nxt;
            r_count      <= w_count_nxt;
            r_drain_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A drain that finds nothing in flight completes on the same edge.
                    if (i_drain) begin
                        if (w_count_nxt == '0) r_drain_done <= 1'b1;
                        else                   r_state      <= DRAIN;
                    end else if (w_accept) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (i_drain) begin
                        if (w_count_nxt == '0) begin
                            r_state      <= IDLE;
                            r_drain_done <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (w_count_nxt == '0) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (w_count_nxt == '0) begin
                        r_state      <= IDLE;
                        r_drain_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_EN_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                          r_stall_cnt <= '0;
        else if (i_flush)                                      r_stall_cnt <= '0;
        else if (r_vld_pipe[N-1] && !i_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_en_ctrl.sv
// Scoreboard bench for pipe_en_ctrl: a behavioural 8-bit datapath follows o_pipe_en,
// accepted data are queued and compared in order at each downstream transfer.
module tb_pipe_en_ctrl;
    localparam int N  = 4;
    localparam int CW = $clog2(N+1);

    logic          i_clk   = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic          i_drain = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_ready, o_valid, o_pipe_en, o_busy, o_drain_done;
    logic [CW-1:0] o_count;
`ifdef PIPE_EN_CTRL_STALL_CNT_EN
    logic [15:0]   o_stall_cnt;
`endif

    logic [7:0] i_data = 8'h00;
    logic [7:0] dp [N];
    logic [7:0] sb_q [$];

    int n_chk = 0, n_err = 0, cyc = 0;
    int n_en = 0, n_xfer = 0, n_vld = 0, n_done = 0, max_cnt = 0;
    int first_vld = -1, en_at_vld = 0, last_xfer = -1, done_cyc = -1;
    int base, en0, x0, v0, d0, g;

    always #5 i_clk = ~i_clk;

    pipe_en_ctrl #(.N(N)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_pipe_en    (o_pipe_en),
        .i_drain      (i_drain),
        .i_flush      (i_flush),
        .o_count      (o_count),
        .o_busy       (o_busy),
        .o_drain_done (o_drain_done)
`ifdef PIPE_EN_CTRL_STALL_CNT_EN
        ,
        .o_stall_cnt  (o_stall_cnt)
`endif
    );

    // Enable-only datapath the controller is sequencing.
    always @(posedge i_clk) begin
        if (o_pipe_en) begin
            dp[0] <= i_data;
            for (int i = 1; i < N; i++) dp[i] <= dp[i-1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, update scoreboard, then return just after the next rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge i_clk);
        if (i_rst_n) begin
            chk("count_vs_sb", 32'(o_count), 32'(sb_q.size()));
            if (o_valid && first_vld < 0) begin
                first_vld = cyc;
                en_at_vld = n_en;
            end
            if (o_pipe_en)    n_en++;
            if (o_valid)      n_vld++;
            if (o_drain_done) begin n_done++; done_cyc = cyc; end
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
            if (i_flush) begin
                sb_q.delete();
            end else begin
                if (o_valid && i_ready) begin
                    e = 'x;
                    if (sb_q.size() != 0) e = sb_q.pop_front();
                    chk("xfer_en", 32'(o_pipe_en), 1);
                    chk("xfer_data", 32'(dp[N-1]), 32'(e));
                    n_xfer++;
                    last_xfer = cyc;
                end
                if (i_valid && o_ready) sb_q.push_back(i_data);
            end
        end
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_empty(input string tag, input int bound);
        int k;
        k = 0;
        while ((o_count != '0 || o_busy) && k < bound) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < bound), 1);
    endtask

    initial begin
        // Reset state, with i_valid high to show the enable stays low.
        i_valid = 1'b1;
        #2;
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_en",    32'(o_pipe_en), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_done",  32'(o_drain_done), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_valid = 1'b0;

        // Streaming: 8 data, both sides always ready.
        i_ready = 1'b1; i_valid = 1'b1;
        base = cyc; en0 = n_en; x0 = n_xfer; first_vld = -1; max_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            i_data = 8'h10 + 8'(k);
            tick();
        end
        chk("s_en_every_cycle", 32'(n_en - en0), 8);
        i_valid = 1'b0;
        wait_empty("s_wait", 20);
        chk("s_latency", 32'(first_vld - base), N);
        chk("s_xfer", 32'(n_xfer - x0), 8);
        chk("s_peak", 32'(max_cnt), 4);

        // Single datum followed by bubbles.
        en0 = n_en; v0 = n_vld; first_vld = -1;
        i_valid = 1'b1; i_data = 8'hA5;
        tick();
        i_valid = 1'b0;
        g = 0;
        while (first_vld < 0 && g < 20) begin tick(); g++; end
        chk("one_vld_seen", 32'(g < 20), 1);
        chk("one_en_to_valid", 32'(en_at_vld - en0), 4);
        wait_empty("one_wait", 20);
        repeat (3) tick();
        chk("one_vld_cycles", 32'(n_vld - v0), 1);
        chk("one_count", 32'(o_count), 0);
        chk("one_idle", 32'(o_busy), 0);

        // Fill, then hold the tail blocked for 6 cycles.
        i_ready = 1'b0; i_valid = 1'b1; x0 = n_xfer;
        for (int k = 0; k < 4; k++) begin
            i_data = 8'h30 + 8'(k);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            i_data = 8'h40 + 8'(k);
            chk("blk_en",    32'(o_pipe_en), 0);
            chk("blk_ready", 32'(o_ready), 0);
            chk("blk_valid", 32'(o_valid), 1);
            chk("blk_data",  32'(dp[N-1]), 'h30);
            tick();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        wait_empty("blk_wait", 20);
        chk("blk_xfer", 32'(n_xfer - x0), 4);

        // Drain with upstream still offering data.
        x0 = n_xfer; d0 = n_done;
        i_valid = 1'b1;
        i_data = 8'h50; tick();
        i_data = 8'h51; tick();
        i_data = 8'h52; i_drain = 1'b1; tick();
        i_drain = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_data = 8'h60 + 8'(k);
            chk("drn_ready", 32'(o_ready), 0);
            tick();
        end
        i_valid = 1'b0;
        g = 0;
        while (n_done == d0 && g < 10) begin tick(); g++; end
        tick();
        chk("drn_xfer", 32'(n_xfer - x0), 3);
        chk("drn_done_once", 32'(n_done - d0), 1);
        chk("drn_done_timing", 32'(done_cyc - last_xfer), 1);
        chk("drn_idle", 32'(o_busy), 0);

        // Drain while already empty.
        i_drain = 1'b1; tick(); i_drain = 1'b0;
        chk("edrn_done", 32'(o_drain_done), 1);
        tick();
        chk("edrn_pulse", 32'(o_drain_done), 0);

        // Flush together with drain while the tail is blocked.
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 8'h70; tick();
        i_data = 8'h71; tick();
        i_valid = 1'b0;
        g = 0;
        while (!o_valid && g < 10) begin tick(); g++; end
        chk("fl_tail_blocked", 32'(o_valid), 1);
        chk("fl_pre_count", 32'(o_count), 2);
        d0 = n_done;
        i_flush = 1'b1; i_drain = 1'b1; i_valid = 1'b1;
        #1;
        chk("fl_ready", 32'(o_ready), 0);
        chk("fl_en", 32'(o_pipe_en), 0);
        tick();
        i_flush = 1'b0; i_drain = 1'b0; i_valid = 1'b0;
        chk("fl_count", 32'(o_count), 0);
        chk("fl_valid", 32'(o_valid), 0);
        chk("fl_busy",  32'(o_busy), 0);
        tick(); tick();
        chk("fl_no_done", 32'(n_done - d0), 0);

`ifdef PIPE_EN_CTRL_STALL_CNT_EN
        chk("stl_after_flush", 32'(o_stall_cnt), 0);
        i_valid = 1'b1; i_data = 8'h80; tick();
        i_valid = 1'b0;
        g = 0;
        while (!o_valid && g < 10) begin tick(); g++; end
        repeat (10) tick();
        chk("stl_10", 32'(o_stall_cnt), 10);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        chk("stl_clr", 32'(o_stall_cnt), 0);
`endif

        // Reset asserted mid-stream, away from a clock edge.
        i_ready = 1'b1; i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_data = 8'h90 + 8'(k);
            tick();
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(o_count), 0);
        chk("arst_valid", 32'(o_valid), 0);
        chk("arst_ready", 32'(o_ready), 1);
        chk("arst_en",    32'(o_pipe_en), 0);
        chk("arst_busy",  32'(o_busy), 0);
        chk("arst_done",  32'(o_drain_done), 0);
        sb_q.delete();
        i_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("arst_after", 32'(o_count), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
